// File: rtl/tdc_fifo_reader.sv
// TDC readout FIFO drain: pops 64-bit timestamps and emits them as two 32-bit
// AXI-Stream beats (low half first). tlast closes packets; an idle timeout pads them shut.
module tdc_fifo_reader #(
  parameter int          PKT_WORDS      = 16,
  parameter int          TIMEOUT_CYCLES = 1024,
  parameter logic [63:0] PAD_WORD       = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        enable,
  input  logic [63:0] fifo_data,
  input  logic        fifo_empty,
  output logic        fifo_rd_en,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic [31:0] words_sent,
  output logic [15:0] pads_sent
);

  localparam int CW = (PKT_WORDS > 1) ? $clog2(PKT_WORDS) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_CAPTURE,
    S_BEAT_LO,
    S_BEAT_HI
  } state_t;

  state_t        state_q, state_d;
  logic [63:0]   word_q, word_d;
  logic [CW-1:0] pkt_cnt_q, pkt_cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          pad_flag_q, pad_flag_d;
  logic [31:0]   words_sent_q, words_sent_d;
  logic [15:0]   pads_sent_q, pads_sent_d;

  logic fetch_ok;
  logic timeout_hit;
  logic last_beat;

  assign fetch_ok    = enable && !fifo_empty;
  assign timeout_hit = (pkt_cnt_q != '0) && (tmo_q == TW'(TIMEOUT_CYCLES));
  assign last_beat   = pad_flag_q || (pkt_cnt_q == CW'(PKT_WORDS - 1));

  always_comb begin
    state_d       = state_q;
    word_d        = word_q;
    pkt_cnt_d     = pkt_cnt_q;
    tmo_d         = '0;
    pad_flag_d    = pad_flag_q;
    words_sent_d  = words_sent_q;
    pads_sent_d   = pads_sent_q;
    fifo_rd_en    = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tlast  = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Data wins over the timeout; the counter only runs while a packet is open.
        if (fetch_ok) begin
          state_d = S_FETCH;
        end else if (timeout_hit) begin
          word_d     = PAD_WORD;
          pad_flag_d = 1'b1;
          state_d    = S_BEAT_LO;
        end else if (pkt_cnt_q != '0) begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_FETCH: begin
        fifo_rd_en = 1'b1;
        state_d    = S_CAPTURE;
      end
      S_CAPTURE: begin
        word_d       = fifo_data;
        words_sent_d = words_sent_q + 32'd1;
        state_d      = S_BEAT_LO;
      end
      S_BEAT_LO: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = word_q[31:0];
        if (m_axis_tready) state_d = S_BEAT_HI;
      end
      S_BEAT_HI: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = word_q[63:32];
        m_axis_tlast  = last_beat;
        if (m_axis_tready) begin
          pkt_cnt_d = last_beat ? '0 : pkt_cnt_q + CW'(1);
          if (pad_flag_q) begin
            pads_sent_d = pads_sent_q + 16'd1;
            pad_flag_d  = 1'b0;
          end
          state_d = fetch_ok ? S_FETCH : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q      <= S_IDLE;
      word_q       <= '0;
      pkt_cnt_q    <= '0;
      tmo_q        <= '0;
      pad_flag_q   <= 1'b0;
      words_sent_q <= '0;
      pads_sent_q  <= '0;
    end else begin
      state_q      <= state_d;
      word_q       <= word_d;
      pkt_cnt_q    <= pkt_cnt_d;
      tmo_q        <= tmo_d;
      pad_flag_q   <= pad_flag_d;
      words_sent_q <= words_sent_d;
      pads_sent_q  <= pads_sent_d;
    end
  end

  assign words_sent = words_sent_q;
  assign pads_sent  = pads_sent_q;

endmodule

// File: tb/tb_tdc_fifo_reader.sv
// Scoreboard bench for tdc_fifo_reader: a behavioural non-FWFT FIFO feeds the DUT,
// stimulus queues expected beats, and a negedge monitor checks every handshake.
module tb_tdc_fifo_reader;

  localparam int PKT = 16;
  localparam int TMO = 1024;

  logic        clk = 1'b0;
  logic        clr;
  logic        enable;
  logic [63:0] fifo_data = '0;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic [31:0] words_sent;
  logic [15:0] pads_sent;

  always #5 clk = ~clk;

  tdc_fifo_reader #(
    .PKT_WORDS     (PKT),
    .TIMEOUT_CYCLES(TMO),
    .PAD_WORD      (64'hFFFF_FFFF_FFFF_FFFF)
  ) dut (
    .clk          (clk),
    .clr          (clr),
    .enable       (enable),
    .fifo_data    (fifo_data),
    .fifo_empty   (fifo_empty),
    .fifo_rd_en   (fifo_rd_en),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast (m_axis_tlast),
    .words_sent   (words_sent),
    .pads_sent    (pads_sent)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural FIFO: data appears one cycle after the pop strobe.
  logic [63:0] fifo_mem [256];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int rd_count = 0;

  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fifo_rd_en) begin
      n_cmp++;
      if (wr_ptr == rd_ptr) begin
        n_bad++;
        $display("FAIL over_read: fifo_rd_en while empty at cycle %0d", cyc);
      end else begin
        fifo_data <= fifo_mem[rd_ptr % 256];
        rd_ptr    <= rd_ptr + 1;
      end
      rd_count <= rd_count + 1;
    end
  end

  logic [32:0] exp_q [$];
  int pkt_pos   = 0;
  int exp_words = 0;
  int exp_pads  = 0;
  logic rand_ready = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Monitor: compares handshaken beats and checks hold-stability while stalled.
  int   tv_rise_cyc = 0;
  int   last_hs_cyc = 0;
  logic prev_tvalid = 1'b0;
  logic pend = 1'b0;
  logic [32:0] pend_beat = '0;

  always @(negedge clk) begin
    if (clr) begin
      pend        = 1'b0;
      prev_tvalid = 1'b0;
    end else begin
      if (pend) begin
        chk("stall_tvalid", {63'd0, m_axis_tvalid}, 64'd1);
        chk("stall_beat", {31'd0, m_axis_tdata, m_axis_tlast}, {31'd0, pend_beat});
      end
      if (m_axis_tvalid && !prev_tvalid) tv_rise_cyc = cyc;
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_beat: got data 0x%0h last %0b, want no beat", m_axis_tdata, m_axis_tlast);
        end else begin
          chk("beat", {31'd0, m_axis_tdata, m_axis_tlast}, {31'd0, exp_q.pop_front()});
        end
        last_hs_cyc = cyc;
        pend = 1'b0;
      end else if (m_axis_tvalid) begin
        pend      = 1'b1;
        pend_beat = {m_axis_tdata, m_axis_tlast};
      end else begin
        pend = 1'b0;
      end
      prev_tvalid = m_axis_tvalid;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) m_axis_tready = 1'($urandom_range(0, 1));
  endtask

  task automatic fifo_push(input logic [63:0] w);
    fifo_mem[wr_ptr % 256] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic expect_word(input logic [63:0] w);
    exp_q.push_back({w[31:0], 1'b0});
    exp_q.push_back({w[63:32], pkt_pos == PKT - 1});
    pkt_pos = (pkt_pos == PKT - 1) ? 0 : pkt_pos + 1;
    exp_words++;
  endtask

  task automatic send_word(input logic [63:0] w);
    expect_word(w);
    fifo_push(w);
  endtask

  task automatic expect_pad();
    exp_q.push_back({32'hFFFF_FFFF, 1'b0});
    exp_q.push_back({32'hFFFF_FFFF, 1'b1});
    pkt_pos = 0;
    exp_pads++;
  endtask

  task automatic wait_exp_le(input int n, input string name);
    int k = 0;
    while (exp_q.size() > n && k < 8000) begin
      tick();
      k++;
    end
    if (exp_q.size() > n) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: %0d beats outstanding, want <= %0d", name, exp_q.size(), n);
    end
  endtask

  initial begin
    int c, first, hs, base, target, k;
    clr = 1'b1;
    enable = 1'b0;
    m_axis_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
    chk("rst_tlast", {63'd0, m_axis_tlast}, 64'd0);
    chk("rst_tdata", {32'd0, m_axis_tdata}, 64'd0);
    chk("rst_rd_en", {63'd0, fifo_rd_en}, 64'd0);
    chk("rst_words", {32'd0, words_sent}, 64'd0);
    chk("rst_pads", {48'd0, pads_sent}, 64'd0);
    clr = 1'b0;
    repeat (3) tick();

    // Single word, then the open packet is closed by a pad.
    enable = 1'b1;
    base = rd_count;
    c = cyc;
    send_word(64'h0123_4567_89AB_CDEF);
    expect_pad();
    wait_exp_le(2, "single");
    chk("latency", 64'(tv_rise_cyc - c), 64'd3);
    chk("single_words", {32'd0, words_sent}, 64'(exp_words));
    chk("single_rd_pulses", 64'(rd_count - base), 64'd1);
    wait_exp_le(0, "single_pad");
    tick();
    chk("single_pads", {48'd0, pads_sent}, 64'(exp_pads));

    // Full packets: 40 words back to back, then a pad after the idle timeout.
    for (int i = 0; i < 40; i++) send_word({32'h1000_0000 + 32'(i), 32'h2000_0000 + 32'(i * 3)});
    expect_pad();
    wait_exp_le(81, "full_first");
    first = tv_rise_cyc;
    wait_exp_le(2, "full_data");
    hs = last_hs_cyc;
    chk("throughput", 64'(hs - first), 64'd157);
    wait_exp_le(0, "full_pad");
    tick();
    chk("pad_timing", 64'(tv_rise_cyc - hs), 64'(TMO + 2));
    chk("full_words", {32'd0, words_sent}, 64'(exp_words));
    chk("full_pads", {48'd0, pads_sent}, 64'(exp_pads));

    // Random backpressure over 100 words.
    base = rd_count;
    rand_ready = 1'b1;
    for (int i = 0; i < 100; i++) send_word({32'hC000_0000 | 32'(i), 32'hA5A5_0000 ^ 32'(i * 7)});
    expect_pad();
    wait_exp_le(0, "bp");
    rand_ready = 1'b0;
    m_axis_tready = 1'b1;
    tick();
    chk("bp_rd_pulses", 64'(rd_count - base), 64'd100);
    chk("bp_words", {32'd0, words_sent}, 64'(exp_words));
    chk("bp_pads", {48'd0, pads_sent}, 64'(exp_pads));

    // A word arriving on the exact timeout cycle is fetched instead of a pad.
    for (int i = 0; i < 3; i++) send_word({32'h7000_0000 + 32'(i), 32'h0BAD_0000 + 32'(i)});
    wait_exp_le(0, "tb_words");
    target = last_hs_cyc + 1 + TMO;
    while (cyc < target) tick();
    chk("boundary_align", 64'(cyc), 64'(target));
    send_word(64'h4444_3333_2222_1111);
    expect_pad();
    wait_exp_le(2, "tb_late_word");
    chk("boundary_no_pad", {48'd0, pads_sent}, 64'(exp_pads - 1));
    wait_exp_le(0, "tb_pad");
    tick();
    chk("boundary_pads", {48'd0, pads_sent}, 64'(exp_pads));

    // enable drop while stalled in the low beat: the word finishes, no further pops.
    m_axis_tready = 1'b0;
    base = rd_count;
    send_word(64'hDEAD_BEEF_CAFE_F00D);
    fifo_push(64'h1111_1111_1111_1111);
    fifo_push(64'h2222_2222_2222_2222);
    k = 0;
    while (!m_axis_tvalid && k < 50) begin tick(); k++; end
    chk("en_reach_lo", {63'd0, m_axis_tvalid}, 64'd1);
    enable = 1'b0;
    m_axis_tready = 1'b1;
    expect_pad();
    wait_exp_le(2, "en_word");
    chk("en_rd_pulses", 64'(rd_count - base), 64'd1);
    wr_ptr = rd_ptr;
    wait_exp_le(0, "en_pad");
    tick();
    chk("en_rd_after_pad", 64'(rd_count - base), 64'd1);
    chk("en_pads", {48'd0, pads_sent}, 64'(exp_pads));

    // clr while stalled in the high beat.
    enable = 1'b1;
    m_axis_tready = 1'b0;
    fifo_push(64'h5555_6666_7777_8888);
    exp_q.push_back({32'h7777_8888, 1'b0});
    k = 0;
    while (!m_axis_tvalid && k < 50) begin tick(); k++; end
    m_axis_tready = 1'b1;
    tick();
    m_axis_tready = 1'b0;
    tick();
    chk("clr_in_hi", {32'd0, m_axis_tdata}, 64'h5555_6666);
    clr = 1'b1;
    #1;
    chk("clr_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
    chk("clr_words", {32'd0, words_sent}, 64'd0);
    chk("clr_pads", {48'd0, pads_sent}, 64'd0);
    tick();
    tick();
    clr = 1'b0;
    pkt_pos = 0;
    exp_words = 0;
    exp_pads = 0;
    m_axis_tready = 1'b1;
    tick();
    send_word(64'h9999_AAAA_BBBB_CCCC);
    expect_pad();
    wait_exp_le(2, "clr_resume");
    chk("clr_resume_words", {32'd0, words_sent}, 64'(exp_words));
    wait_exp_le(0, "clr_resume_pad");
    tick();
    chk("clr_resume_pads", {48'd0, pads_sent}, 64'(exp_pads));

    repeat (5) tick();
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
